// File: rtl/suma_pkg.sv
// Shared types and flag bit positions for the multi-word add sequencer.
package suma_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam int BAND_N = 3;
    localparam int BAND_Z = 2;
    localparam int BAND_C = 1;
    localparam int BAND_V = 0;
endpackage

// File: rtl/suma_cin.sv
// Combinational n-bit adder with carry-in; carry-out kept as a separate bit.
module suma_cin #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
endmodule

// File: rtl/suma_multipalabra_ctrl.sv
// Sequencer that adds two N*WORDS-bit operands one N-bit word per cycle, LSW first,
// rippling carry through a register and producing {N,Z,C,V} for the wide result.
//
//  state | meaning
//  IDLE  | ready for a new request; res/banderas hold the last result
//  SUMA  | adding word idx, one word per cycle
//  DONE  | result valid, held until the consumer takes it
module suma_multipalabra_ctrl
    import suma_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [N*WORDS-1:0]   op_a,
    input  logic [N*WORDS-1:0]   op_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N*WORDS-1:0]   res,
    output logic [3:0]           banderas
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    estado_t        estado, estado_sig;
    logic [W-1:0]   a_q, b_q, res_q, res_sig;
    logic [3:0]     band_q;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [N-1:0]   wa, wb, ws;
    logic           wc;
    logic           aceptar, ultima;

    assign wa = a_q[idx*N +: N];
    assign wb = b_q[idx*N +: N];

    suma_cin #(.n(N)) u_suma (
        .a    (wa),
        .b    (wb),
        .cin  (carry),
        .s    (ws),
        .cout (wc)
    );

    // Full result including the word being written this cycle, so Z covers all W bits.
    always_comb begin
        res_sig = res_q;
        res_sig[idx*N +: N] = ws;
    end

    assign aceptar = start_valid && start_ready;
    assign ultima  = (estado == SUMA) && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig  = estado;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        case (estado)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) estado_sig = SUMA;
            end
            SUMA: begin
                if (idx == IDX_LAST) estado_sig = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            band_q <= '0;
            idx    <= '0;
            carry  <= 1'b0;
        end else begin
            if (aceptar) begin
                a_q   <= op_a;
                b_q   <= op_b;
                idx   <= '0;
                carry <= 1'b0;
            end
            if (estado == SUMA) begin
                res_q <= res_sig;
                carry <= wc;
                if (idx != IDX_LAST) idx <= idx + 1'b1;
            end
            if (ultima) begin
                band_q[BAND_N] <= res_sig[W-1];
                band_q[BAND_Z] <= (res_sig == '0);
                band_q[BAND_C] <= wc;
                band_q[BAND_V] <= (a_q[W-1] == b_q[W-1]) && (res_sig[W-1] != a_q[W-1]);
            end
        end
    end

    assign res      = res_q;
    assign banderas = band_q;
endmodule

// File: tb/tb_suma_multipalabra_ctrl.sv
// Self-checking bench for the multi-word add sequencer (N=4, WORDS=4).
module tb_suma_multipalabra_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res;
    logic [3:0]  banderas;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  f;
    } exp_t;
    exp_t sb[$];

    suma_multipalabra_ctrl #(.N(4), .WORDS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .banderas    (banderas)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t modelo(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        exp_t e;
        s = {1'b0, a} + {1'b0, b};
        e.r = s[15:0];
        e.f = {s[15], (s[15:0] == 16'h0), s[16], (a[15] == b[15]) && (s[15] != a[15])};
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic push,
                         input exp_t e, output int t_acc);
        int k;
        k = 0;
        while (!start_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!start_ready) begin
            failures++;
            $display("FAIL issue_ready_timeout: start_ready=%0b required 1", start_ready);
        end
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        @(posedge clk);
        t_acc = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        start_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
    endtask

    task automatic wait_result(output int lat, output bit ok);
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL result_timeout: res_valid=%0b after %0d cycles, required 1", res_valid, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, res_valid, res, banderas} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
            failures++;
            $display("FAIL reset_state: ready=%0b valid=%0b res=%h band=%b required 1 0 0000 0000",
                     start_ready, res_valid, res, banderas);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] ta [4] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] tb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
        logic [15:0] tr [4] = '{16'h0100, 16'h0000, 16'h8000, 16'h0000};
        logic [3:0]  tf [4] = '{4'b0000, 4'b0110, 4'b1001, 4'b0111};
        exp_t e;
        int t, lat;
        bit ok;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.r = tr[i];
            e.f = tf[i];
            issue(ta[i], tb[i], 1'b1, e, t);
            wait_result(lat, ok);
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL basic_latency[%0d]: %0d cycles required 4", i, lat);
            end
            if (ok && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (res !== e.r || banderas !== e.f) begin
                    failures++;
                    $display("FAIL basic_result[%0d]: res=%h band=%b required %h %b",
                             i, res, banderas, e.r, e.f);
                end
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
                failures++;
                $display("FAIL basic_return_idle[%0d]: valid=%0b ready=%0b required 0 1",
                         i, res_valid, start_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [15:0] r0;
        logic [3:0]  f0;
        int t, lat;
        bit ok;
        res_ready = 1'b0;
        issue(16'hAAAA, 16'h1111, 1'b1, modelo(16'hAAAA, 16'h1111), t);
        wait_result(lat, ok);
        e = sb.pop_front();
        checks++;
        if (res !== e.r || banderas !== e.f) begin
            failures++;
            $display("FAIL bp_result: res=%h band=%b required %h %b", res, banderas, e.r, e.f);
        end
        r0 = e.r;
        f0 = e.f;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start_valid = 1'b1;
                op_a = 16'h5555;
                op_b = 16'h5555;
            end else begin
                start_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (res !== r0 || banderas !== f0 || start_ready !== 1'b0 || res_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: res=%h band=%b ready=%0b valid=%0b required %h %b 0 1",
                         i, res, banderas, start_ready, res_valid, r0, f0);
            end
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1 || res !== r0 || banderas !== f0) begin
            failures++;
            $display("FAIL bp_release: valid=%0b ready=%0b res=%h band=%b required 0 1 %h %b",
                     res_valid, start_ready, res, banderas, r0, f0);
        end
        e.r = 16'h2345;
        e.f = 4'b0000;
        issue(16'h1234, 16'h1111, 1'b1, e, t);
        wait_result(lat, ok);
        e = sb.pop_front();
        checks++;
        if (res !== e.r || banderas !== e.f || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_next: res=%h band=%b pending=%0d required %h %b 0",
                     res, banderas, sb.size(), e.r, e.f);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int t, lat;
        bit ok;
        res_ready = 1'b1;
        e = '0;
        issue(16'h3333, 16'h4444, 1'b0, e, t);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, res_valid, res, banderas} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
            failures++;
            $display("FAIL reset_mid: ready=%0b valid=%0b res=%h band=%b required 1 0 0000 0000",
                     start_ready, res_valid, res, banderas);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e.r = 16'h1010;
        e.f = 4'b0000;
        issue(16'h0F0F, 16'h0101, 1'b1, e, t);
        wait_result(lat, ok);
        e = sb.pop_front();
        checks++;
        if (res !== e.r || banderas !== e.f || lat !== 4) begin
            failures++;
            $display("FAIL reset_recover: res=%h band=%b lat=%0d required %h %b 4",
                     res, banderas, lat, e.r, e.f);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [15:0] a, b;
        int t, t_prev, lat;
        bit ok;
        res_ready = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 16'hFFFF : 16'($urandom);
            b = (i == 0) ? 16'hFFFF : 16'($urandom);
            issue(a, b, 1'b1, modelo(a, b), t);
            if (i > 0) begin
                checks++;
                if (t - t_prev !== 6) begin
                    failures++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles required 6", i, t - t_prev);
                end
            end
            t_prev = t;
            wait_result(lat, ok);
            e = sb.pop_front();
            checks++;
            if (res !== e.r || banderas !== e.f) begin
                failures++;
                $display("FAIL b2b_result[%0d]: %h+%h res=%h band=%b required %h %b",
                         i, a, b, res, banderas, e.r, e.f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
